// File: rtl/aes_inv_round_orchestrator_if.sv
// Bundle between the AES-128 decrypt round orchestrator, its key source,
// the external inverse-round datapath and the plaintext consumer.
interface aes_inv_round_orchestrator_if #(
   parameter int WIDTH = 128
);
   logic             start;
   logic [WIDTH-1:0] data;
   logic [WIDTH-1:0] key [0:10];
   logic [WIDTH-1:0] rnd_result;
   logic [WIDTH-1:0] rnd_state;
   logic [WIDTH-1:0] rnd_key;
   logic             rnd_last;
   logic [3:0]       round;
   logic [WIDTH-1:0] data_final;
   logic             data_valid;
   logic             data_ready;
   logic             busy;
   logic             done;

   modport master (
      output start, data, key, rnd_result, data_ready,
      input  rnd_state, rnd_key, rnd_last, round, data_final, data_valid, busy, done
   );

   modport slave (
      input  start, data, key, rnd_result, data_ready,
      output rnd_state, rnd_key, rnd_last, round, data_final, data_valid, busy, done
   );
endinterface

// File: rtl/aes_inv_round_orchestrator.sv
// AES-128 decrypt sequencer: initial AddRoundKey with key 10, then ten inverse
// rounds (keys 9..0) through an external combinational datapath, one per clock.
module aes_inv_round_orchestrator #(
   parameter int WIDTH  = 128,
   parameter int ROUNDS = 10
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   aes_inv_round_orchestrator_if.slave  bus
);
   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ROUND = 2'd1,
      DONE  = 2'd2
   } fsm_t;

   fsm_t             fsm_q, fsm_d;
   logic [WIDTH-1:0] state_q, state_d;
   logic [3:0]       round_q, round_d;
   logic [WIDTH-1:0] key_sel;
   logic             in_round;

   assign in_round = (fsm_q == ROUND);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         fsm_q   <= IDLE;
         state_q <= '0;
         round_q <= '0;
      end else begin
         fsm_q   <= fsm_d;
         state_q <= state_d;
         round_q <= round_d;
      end
   end

   // Key 0 doubles as the idle value, so only indices 1..ROUNDS need decoding.
   always_comb begin
      key_sel = bus.key[0];
      if (in_round) begin
         for (int unsigned i = 1; i <= ROUNDS; i++) begin
            if (round_q == 4'(i)) key_sel = bus.key[i];
         end
      end
   end

   always_comb begin
      fsm_d   = fsm_q;
      state_d = state_q;
      round_d = round_q;
      unique case (fsm_q)
         IDLE: begin
            if (bus.start) begin
               state_d = bus.data ^ bus.key[ROUNDS];
               round_d = 4'(ROUNDS - 1);
               fsm_d   = ROUND;
            end
         end
         ROUND: begin
            state_d = bus.rnd_result;
            if (round_q == 4'd0) fsm_d   = DONE;
            else                 round_d = round_q - 4'd1;
         end
         DONE: begin
            if (bus.data_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
   end

   assign bus.rnd_state  = state_q;
   assign bus.rnd_key    = key_sel;
   assign bus.rnd_last   = in_round && (round_q == 4'd0);
   assign bus.round      = in_round ? round_q : 4'd0;
   assign bus.data_final = state_q;
   assign bus.data_valid = (fsm_q == DONE);
   assign bus.busy       = (fsm_q != IDLE);
   assign bus.done       = (fsm_q == DONE) && bus.data_ready;
endmodule

// File: tb/tb_aes_inv_round_orchestrator.sv
// Directed bench for the AES-128 decrypt orchestrator with a behavioural
// inverse-round datapath and key expansion built from GF(2^8) arithmetic.
module tb_aes_inv_round_orchestrator;
   logic clk = 1'b0;
   logic rst;
   int   total = 0;
   int   bad   = 0;
   logic [127:0] rk [0:10];

   localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;

   always #5 clk = ~clk;

   aes_inv_round_orchestrator_if #(.WIDTH(128)) bus ();

   aes_inv_round_orchestrator #(.WIDTH(128), .ROUNDS(10)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x, y;
      p = 8'h00; x = a; y = b;
      for (int i = 0; i < 8; i++) begin
         if (y[0]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
         y = y >> 1;
      end
      return p;
   endfunction

   // x^254 is the multiplicative inverse (and maps 0 to 0).
   function automatic logic [7:0] gf_inv(input logic [7:0] x);
      logic [7:0] r, p;
      r = 8'h01; p = x;
      for (int i = 0; i < 7; i++) begin
         p = gmul(p, p);
         r = gmul(r, p);
      end
      return r;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return 8'((b << n) | (b >> (8 - n)));
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [7:0] b;
      b = gf_inv(x);
      return b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return gf_inv(rotl8(x, 1) ^ rotl8(x, 3) ^ rotl8(x, 6) ^ 8'h05);
   endfunction

   function automatic logic [7:0] gb(input logic [127:0] s, input int i);
      return s[127-8*i -: 8];
   endfunction

   function automatic logic [127:0] inv_round(input logic [127:0] s, input logic [127:0] k,
                                              input logic last);
      logic [127:0] t, u;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++)
         for (int r = 0; r < 4; r++)
            t[127-8*(4*c+r) -: 8] = inv_sbox(gb(s, 4*((c - r + 4) % 4) + r));
      t = t ^ k;
      if (last) return t;
      for (int c = 0; c < 4; c++) begin
         a0 = gb(t, 4*c); a1 = gb(t, 4*c+1); a2 = gb(t, 4*c+2); a3 = gb(t, 4*c+3);
         u[127-8*(4*c)   -: 8] = gmul(a0,8'h0e)^gmul(a1,8'h0b)^gmul(a2,8'h0d)^gmul(a3,8'h09);
         u[127-8*(4*c+1) -: 8] = gmul(a0,8'h09)^gmul(a1,8'h0e)^gmul(a2,8'h0b)^gmul(a3,8'h0d);
         u[127-8*(4*c+2) -: 8] = gmul(a0,8'h0d)^gmul(a1,8'h09)^gmul(a2,8'h0e)^gmul(a3,8'h0b);
         u[127-8*(4*c+3) -: 8] = gmul(a0,8'h0b)^gmul(a1,8'h0d)^gmul(a2,8'h09)^gmul(a3,8'h0e);
      end
      return u;
   endfunction

   always_comb bus.rnd_result = inv_round(bus.rnd_state, bus.rnd_key, bus.rnd_last);

   task automatic expand(input logic [127:0] key);
      logic [31:0] w [0:43];
      logic [31:0] tmp;
      logic [7:0]  rcon;
      rcon = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox(tmp[31:24]), sbox(tmp[23:16]), sbox(tmp[15:8]), sbox(tmp[7:0])};
            tmp[31:24] = tmp[31:24] ^ rcon;
            rcon = gmul(rcon, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) begin
         rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
         bus.key[r] = rk[r];
      end
   endtask

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // bp: cycles of ready=0 once valid is up; trace: check round/last/key each round;
   // poke: raise start with other data at round 5 and during DONE.
   task automatic run_op(input logic [127:0] ct, input logic [127:0] pt, input int bp,
                         input bit trace, input bit poke, input string tag);
      int cyc;
      cyc = 0;
      bus.data_ready = (bp == 0);
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.data  = ct;
      while (cyc < 40) begin
         @(posedge clk); #1;
         cyc++;
         if (cyc == 1) begin
            bus.start = 1'b0;
            bus.data  = '1;
         end
         if (bus.data_valid) break;
         if (trace && cyc <= 10) begin
            check({tag, ":round"}, 128'(bus.round), 128'(10 - cyc));
            check({tag, ":last"}, 128'(bus.rnd_last), 128'(cyc == 10));
            check({tag, ":key"}, bus.rnd_key, rk[10 - cyc]);
         end
         if (poke) begin
            if (bus.round == 4'd5) begin
               bus.start = 1'b1;
               bus.data  = ~ct;
            end else begin
               bus.start = 1'b0;
            end
         end
      end
      check({tag, ":latency"}, 128'(cyc), 128'(11));
      check({tag, ":pt"}, bus.data_final, pt);
      if (bp > 0) begin
         if (poke) begin
            bus.start = 1'b1;
            bus.data  = ~ct;
         end
         check({tag, ":done_held"}, 128'(bus.done), 128'(0));
         for (int i = 0; i < bp; i++) begin
            @(posedge clk); #1;
            check({tag, ":bp_valid"}, 128'(bus.data_valid), 128'(1));
            check({tag, ":bp_pt"}, bus.data_final, pt);
            check({tag, ":bp_done"}, 128'(bus.done), 128'(0));
         end
         bus.start = 1'b0;
         bus.data_ready = 1'b1;
         #1;
      end
      check({tag, ":done"}, 128'(bus.done), 128'(1));
      @(posedge clk); #1;
      check({tag, ":idle_busy"}, 128'(bus.busy), 128'(0));
      check({tag, ":idle_done"}, 128'(bus.done), 128'(0));
      if (poke) begin
         @(posedge clk); #1;
         check({tag, ":no_second"}, 128'(bus.busy), 128'(0));
      end
   endtask

   initial begin
      int first, second, t, wait_cyc;
      logic prev;
      rst = 1'b1;
      bus.start = 1'b0;
      bus.data = '0;
      bus.data_ready = 1'b1;
      expand(C1_KEY);
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy",  128'(bus.busy), 128'(0));
      check("rst_valid", 128'(bus.data_valid), 128'(0));
      check("rst_done",  128'(bus.done), 128'(0));
      check("rst_round", 128'(bus.round), 128'(0));
      check("rst_last",  128'(bus.rnd_last), 128'(0));
      check("rst_final", bus.data_final, 128'(0));
      rst = 1'b0;

      run_op(C1_CT, C1_PT, 0, 1'b0, 1'b0, "c1");

      expand(B_KEY);
      run_op(B_CT, B_PT, 0, 1'b1, 1'b0, "appb");

      expand(C1_KEY);
      run_op(C1_CT, C1_PT, 5, 1'b0, 1'b0, "bp");
      run_op(C1_CT, C1_PT, 3, 1'b0, 1'b1, "busy_start");

      // Reset while round 3 is in flight.
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.data  = C1_CT;
      @(posedge clk); #1;
      bus.start = 1'b0;
      wait_cyc = 0;
      while (bus.round != 4'd3 && wait_cyc < 20) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      check("mid_reach_r3", 128'(bus.round), 128'(3));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("mid_busy",  128'(bus.busy), 128'(0));
      check("mid_valid", 128'(bus.data_valid), 128'(0));
      check("mid_round", 128'(bus.round), 128'(0));
      check("mid_final", bus.data_final, 128'(0));
      run_op(C1_CT, C1_PT, 0, 1'b0, 1'b0, "after_rst");

      // Start held high: valid must rise every 12 cycles.
      bus.data_ready = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b1;
      bus.data  = C1_CT;
      first = -1; second = -1; prev = 1'b0;
      for (t = 1; t <= 40; t++) begin
         @(posedge clk); #1;
         if (bus.data_valid && !prev) begin
            if (first < 0) first = t;
            else if (second < 0) second = t;
            check("b2b_pt", bus.data_final, C1_PT);
         end
         prev = bus.data_valid;
      end
      bus.start = 1'b0;
      check("b2b_first", 128'(first), 128'(11));
      check("b2b_gap", 128'(second - first), 128'(12));
      wait_cyc = 0;
      while (bus.busy && wait_cyc < 30) begin
         @(posedge clk); #1;
         wait_cyc++;
      end
      check("b2b_drain", 128'(bus.busy), 128'(0));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
